can_vend_ctrl: RTL and testbench

Vending controller that drives a can-stock counter through its `load`/`count`/`dispense` interface and observes its stock status. It accepts coins, accumulates credit, and issues one `dispense` pulse per purchase. It returns change and refunds as nickel pulses and performs restock loads. It sits between the coin mechanism/front panel and the stock counter, on the same clock.

---
 rtl/can_vend_ctrl.sv | 156 +++++++++++++++
 tb/tb_can_vend_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_vend_ctrl.sv
// can_vend_ctrl: coin-accepting vending controller driving a can-stock counter
// through load/count/dispense. All outputs are registered.
// Optional feature macro: CAN_VEND_CHANGE_EN. When defined, refunds and
// overpayment are returned as change_nickel pulses. When undefined, there is
// no change state, refund is ignored, and any overpayment is forfeited at vend.
//
// state   | meaning
// IDLE    | accept coins, arbitrate restock / refund / vend
// VEND    | one dispense cycle, deduct price
// CHANGE  | one nickel returned per cycle until credit is zero
// RESTOCK | one load cycle presenting the latched count
module can_vend_ctrl #(
    parameter int PRICE      = 35,
    parameter int CREDIT_MAX = 95
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       refund,
    input  logic       restock,
    input  logic [7:0] restock_count,
    input  logic       stock_out,
    output logic       load,
    output logic [7:0] count,
    output logic       dispense,
    output logic       coin_reject,
    output logic       change_nickel,
    output logic [7:0] credit,
    output logic       busy
);

    localparam logic [8:0] PRICE_W      = 9'(PRICE);
    localparam logic [8:0] CREDIT_MAX_W = 9'(CREDIT_MAX);
    localparam logic [7:0] PRICE_B      = 8'(PRICE);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, RESTOCK} state_t;

    state_t     state;
    logic [8:0] coin_amount;
    logic       coin_fits;
    logic       credit_ge_price;

`ifdef CAN_VEND_CHANGE_EN
    localparam logic [7:0] NICKEL = 8'd5;
    logic [7:0] remainder;
    assign remainder = credit - PRICE_B;
`else
    logic [7:0] unused_price_b;
    logic       unused_refund;
    assign unused_price_b = PRICE_B;
    assign unused_refund  = refund;
`endif

    // Decode the coin code and decide whether it would fit under the credit cap.
    always_comb begin
        coin_amount = 9'd0;
        case (coin_val)
            2'd0:    coin_amount = 9'd5;
            2'd1:    coin_amount = 9'd10;
            2'd2:    coin_amount = 9'd25;
            default: coin_amount = 9'd0;
        endcase
        coin_fits       = (coin_val != 2'd3) && (({1'b0, credit} + coin_amount) <= CREDIT_MAX_W);
        credit_ge_price = ({1'b0, credit} >= PRICE_W);
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            count         <= '0;
            load          <= 1'b0;
            dispense      <= 1'b0;
            coin_reject   <= 1'b0;
            change_nickel <= 1'b0;
            busy          <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (restock) begin
                        state       <= RESTOCK;
                        count       <= restock_count;
                        load        <= 1'b1;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end
`ifdef CAN_VEND_CHANGE_EN
                    else if (refund && credit != 8'd0) begin
                        state         <= CHANGE;
                        change_nickel <= 1'b1;
                        busy          <= 1'b1;
                        coin_reject   <= coin_valid;
                    end
`endif
                    else if (credit_ge_price && !stock_out) begin
                        state       <= VEND;
                        dispense    <= 1'b1;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (coin_fits) credit <= credit + coin_amount[7:0];
                        else           coin_reject <= 1'b1;
                    end
                end
                VEND: begin
                    dispense    <= 1'b0;
                    coin_reject <= coin_valid;
`ifdef CAN_VEND_CHANGE_EN
                    credit <= remainder;
                    if (remainder != 8'd0) begin
                        state         <= CHANGE;
                        change_nickel <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    credit <= '0;
                    state  <= IDLE;
                    busy   <= 1'b0;
`endif
                end
`ifdef CAN_VEND_CHANGE_EN
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (credit <= NICKEL) begin
                        credit        <= '0;
                        state         <= IDLE;
                        change_nickel <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        credit <= credit - NICKEL;
                    end
                end
`endif
                RESTOCK: begin
                    load        <= 1'b0;
                    coin_reject <= coin_valid;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    load          <= 1'b0;
                    dispense      <= 1'b0;
                    change_nickel <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_vend_ctrl.sv
// Testbench for can_vend_ctrl: directed vector table, hand-written corner
// sequences, then randomized stimulus against a schedule-based reference model.
module tb_can_vend_ctrl;

    localparam int PRICE      = 35;
    localparam int CREDIT_MAX = 95;
`ifdef CAN_VEND_CHANGE_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, coin_valid, refund, restock, stock_out;
    logic [1:0] coin_val;
    logic [7:0] restock_count;
    logic       load, dispense, coin_reject, change_nickel, busy;
    logic [7:0] count, credit;

    int checks   = 0;
    int failures = 0;

    can_vend_ctrl #(.PRICE(PRICE), .CREDIT_MAX(CREDIT_MAX)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
        .refund(refund), .restock(restock), .restock_count(restock_count),
        .stock_out(stock_out), .load(load), .count(count), .dispense(dispense),
        .coin_reject(coin_reject), .change_nickel(change_nickel),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, cv;
        bit [1:0] cval;
        bit       rf, rs;
        bit [7:0] rc;
        bit       so;
        bit       e_load, e_disp, e_rej, e_nick;
        int       e_credit;
        bit       e_busy;
        int       e_count;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit cv, bit [1:0] cval, bit rf, bit rs, bit [7:0] rc, bit so,
                                bit el, bit ed, bit er, bit en, int ecr, bit eb, int ecnt);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cval = cval; v.rf = rf; v.rs = rs; v.rc = rc; v.so = so;
        v.e_load = el; v.e_disp = ed; v.e_rej = er; v.e_nick = en;
        v.e_credit = ecr; v.e_busy = eb; v.e_count = ecnt;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst, bit cv, bit [1:0] cval, bit rf, bit rs, bit [7:0] rc, bit so);
        reset = rst; coin_valid = cv; coin_val = cval; refund = rf;
        restock = rs; restock_count = rc; stock_out = so;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string nm, bit el, bit ed, bit er, bit en, int ecr, bit eb);
        chk({nm, ".load"}, load, el);
        chk({nm, ".dispense"}, dispense, ed);
        chk({nm, ".coin_reject"}, coin_reject, er);
        chk({nm, ".change_nickel"}, change_nickel, en);
        chk({nm, ".credit"}, credit, ecr);
        chk({nm, ".busy"}, busy, eb);
    endtask

    // ---------------- reference model ----------------
    // Each busy episode is expanded into a schedule of future cycles.
    typedef struct { int cr; } slot_t;
    slot_t plan[$];
    int  m_credit, m_count, m_final;
    bit  m_busy, m_load, m_disp, m_nick, m_rej;
    int  coin_cents[4] = '{5, 10, 25, 0};

    task automatic model_edge();
        bit rej;
        slot_t s;
        rej = 1'b0;
        if (reset) begin
            plan.delete();
            m_credit = 0; m_count = 0; m_final = 0;
            m_busy = 0; m_load = 0; m_disp = 0; m_nick = 0;
        end else if (m_busy) begin
            rej = coin_valid;
            m_load = 0; m_disp = 0;
            if (plan.size() > 0) begin
                s = plan.pop_front();
                m_nick = 1; m_credit = s.cr;
            end else begin
                m_nick = 0; m_busy = 0; m_credit = m_final;
            end
        end else if (restock) begin
            m_load = 1; m_busy = 1; m_count = int'(restock_count);
            m_final = m_credit; rej = coin_valid;
        end else if (CE && refund && m_credit > 0) begin
            for (int c = m_credit; c > 0; c -= 5) begin s.cr = c; plan.push_back(s); end
            s = plan.pop_front();
            m_nick = 1; m_busy = 1; m_credit = s.cr; m_final = 0; rej = coin_valid;
        end else if (m_credit >= PRICE && !stock_out) begin
            m_disp = 1; m_busy = 1; m_final = 0; rej = coin_valid;
            if (CE)
                for (int c = m_credit - PRICE; c > 0; c -= 5) begin s.cr = c; plan.push_back(s); end
        end else if (coin_valid) begin
            if (coin_val != 2'd3 && m_credit + coin_cents[coin_val] <= CREDIT_MAX)
                m_credit += coin_cents[coin_val];
            else
                rej = 1'b1;
        end
        m_rej = rej;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        // ---------------- table vectors ----------------
        tbl.push_back(mk(1,0,0,0,0,  0,0, 0,0,0,0,  0,0,  0));
        tbl.push_back(mk(0,1,2,0,0,  0,0, 0,0,0,0, 25,0,  0));
        tbl.push_back(mk(0,1,1,0,0,  0,0, 0,0,0,0, 35,0,  0));
        tbl.push_back(mk(0,0,0,0,0,  0,0, 0,1,0,0, 35,1,  0));
        tbl.push_back(mk(0,0,0,0,0,  0,0, 0,0,0,0,  0,0,  0));
        tbl.push_back(mk(0,1,3,0,0,  0,0, 0,0,1,0,  0,0,  0));
        tbl.push_back(mk(0,0,0,0,0,  0,0, 0,0,0,0,  0,0,  0));
        tbl.push_back(mk(0,1,2,0,1,200,0, 1,0,1,0,  0,1,200));
        tbl.push_back(mk(0,0,0,0,0,  0,0, 0,0,0,0,  0,0,200));
        tbl.push_back(mk(0,1,2,0,0,  0,1, 0,0,0,0, 25,0,200));
        tbl.push_back(mk(0,1,2,0,0,  0,1, 0,0,0,0, 50,0,200));
        tbl.push_back(mk(0,1,2,0,0,  0,1, 0,0,0,0, 75,0,200));
        tbl.push_back(mk(0,1,2,0,0,  0,1, 0,0,1,0, 75,0,200));
        tbl.push_back(mk(0,1,1,0,0,  0,1, 0,0,0,0, 85,0,200));
        tbl.push_back(mk(0,1,1,0,0,  0,1, 0,0,0,0, 95,0,200));
        tbl.push_back(mk(0,1,0,0,0,  0,1, 0,0,1,0, 95,0,200));
        tbl.push_back(mk(1,0,0,0,0,  0,0, 0,0,0,0,  0,0,  0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].cv, tbl[i].cval, tbl[i].rf, tbl[i].rs, tbl[i].rc, tbl[i].so);
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].e_load, tbl[i].e_disp, tbl[i].e_rej,
                       tbl[i].e_nick, tbl[i].e_credit, tbl[i].e_busy);
            chk($sformatf("tbl%0d.count", i), count, tbl[i].e_count);
        end

        // ---------------- overpay: two quarters, change, coin during CHANGE ----------------
        drive(0, 1, 2, 0, 0, 0, 0); step();
        drive(0, 1, 2, 0, 0, 0, 0); step();
        expect_out("op.credit50", 0, 0, 0, 0, 50, 0);
        drive(0, 0, 0, 0, 0, 0, 0); step();
        expect_out("op.vend", 0, 1, 0, 0, 50, 1);
        step();
        if (CE) begin
            expect_out("op.chg15", 0, 0, 0, 1, 15, 1);
            drive(0, 1, 0, 0, 0, 0, 0); step();
            expect_out("op.chg10_rej", 0, 0, 1, 1, 10, 1);
            drive(0, 0, 0, 0, 0, 0, 0); step();
            expect_out("op.chg5", 0, 0, 0, 1, 5, 1);
            step();
            expect_out("op.idle", 0, 0, 0, 0, 0, 0);
        end else begin
            expect_out("op.forfeit", 0, 0, 0, 0, 0, 0);
            step();
            expect_out("op.idle", 0, 0, 0, 0, 0, 0);
        end

        // ---------------- stock_out hold, then refund ----------------
        drive(0, 1, 2, 0, 0, 0, 1); step();
        drive(0, 1, 1, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        begin
            int disp_seen;
            disp_seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                disp_seen += int'(dispense);
                if (i == 19) chk("so.credit_held", credit, 35);
            end
            chk("so.no_dispense", disp_seen, 0);
        end
        drive(0, 0, 0, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 1);
        begin
            int nicks, ok_seq;
            nicks = 0; ok_seq = 1;
            for (int i = 0; i < 12; i++) begin
                if (change_nickel) begin
                    if (int'(credit) != 35 - 5 * nicks) ok_seq = 0;
                    nicks++;
                end
                step();
            end
            chk("rf.nickels", nicks, CE ? 7 : 0);
            chk("rf.credit_seq", ok_seq, 1);
            chk("rf.credit_end", credit, CE ? 0 : 35);
        end
        drive(1, 0, 0, 0, 0, 0, 0); step();

        // ---------------- reset on 2nd CHANGE cycle of 50-cent overpay ----------------
        drive(0, 1, 2, 0, 0, 0, 0); step();
        step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        step();
        if (CE) begin
            expect_out("rs.chg1", 0, 0, 0, 1, 15, 1);
            step();
            expect_out("rs.chg2", 0, 0, 0, 1, 10, 1);
        end
        drive(1, 0, 0, 0, 0, 0, 0); step();
        expect_out("rs.after", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0); step();
        expect_out("rs.quiet", 0, 0, 0, 0, 0, 0);

        // ---------------- randomized against reference model ----------------
        drive(1, 0, 0, 0, 0, 0, 0);
        model_edge();
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 1) == 1),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 24) == 0),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0));
            model_edge();
            step();
            expect_out($sformatf("rnd%0d", cyc), m_load, m_disp, m_rej, m_nick, m_credit, m_busy);
            chk($sformatf("rnd%0d.count", cyc), count, m_count);
            chk($sformatf("rnd%0d.load_disp_excl", cyc), int'(load & dispense), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
